ras_stack_ctrl: RTL and testbench

- Return-address-stack controller for the jal/jalr prediction path; owns the circular RAS storage, top-of-stack pointer, occupancy count and the ra-track register.
- Consumes the RAS_push/RAS_pop/RAS_rollback_* and WR_ra_track_* strobes from the hazard/control unit.
- Supplies the predicted return target to IF and the RAS_ra_track value back to the hazard/control unit.
- Speculative pops are undone by re-advancing the pointer over non-erased slots; speculative pushes are undone by retreating it.

---
 rtl/ras_stack_ctrl_if.sv | 46 ++++
 rtl/ras_stack_ctrl.sv | 108 ++++++++++
 tb/tb_ras_stack_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_stack_ctrl_if.sv
// ras_stack_ctrl_if
// Bundles the strobes and results exchanged between the hazard/control unit
// and the return-address-stack controller.
//   master : hazard/control unit side. Drives the push/pop/rollback/ra-track
//            strobes and push_addr, and reads the RAS results.
//   slave  : RAS controller side.
// Signals:
//   RAS_push, RAS_pop       push push_addr / pop the top entry
//   push_addr [XLEN]        return address to push (PC+4 of jal/jalr)
//   RAS_rollback_pop_id     flush undo of a push issued by the ID instruction
//   RAS_rollback_push_id    flush undo of a pop issued by the ID instruction
//   RAS_rollback_push_ex    flush undo of a pop issued by the EX instruction
//   WR_ra_track_en/_data    ra-track register write
//   RAS_top [XLEN]          predicted return address
//   RAS_empty, RAS_full     occupancy flags
//   RAS_ra_track [5]        register index currently holding a copy of ra
interface ras_stack_ctrl_if #(
  parameter int XLEN = 32
);
  logic            RAS_push;
  logic            RAS_pop;
  logic [XLEN-1:0] push_addr;
  logic            RAS_rollback_pop_id;
  logic            RAS_rollback_push_id;
  logic            RAS_rollback_push_ex;
  logic            WR_ra_track_en;
  logic [4:0]      WR_ra_track_data;
  logic [XLEN-1:0] RAS_top;
  logic            RAS_empty;
  logic            RAS_full;
  logic [4:0]      RAS_ra_track;

  modport master (
    output RAS_push, RAS_pop, push_addr,
           RAS_rollback_pop_id, RAS_rollback_push_id, RAS_rollback_push_ex,
           WR_ra_track_en, WR_ra_track_data,
    input  RAS_top, RAS_empty, RAS_full, RAS_ra_track
  );

  modport slave (
    input  RAS_push, RAS_pop, push_addr,
           RAS_rollback_pop_id, RAS_rollback_push_id, RAS_rollback_push_ex,
           WR_ra_track_en, WR_ra_track_data,
    output RAS_top, RAS_empty, RAS_full, RAS_ra_track
  );
endinterface

// File: rtl/ras_stack_ctrl.sv
// ras_stack_ctrl
// Return-address-stack controller for jal/jalr prediction. Owns a circular
// stack of DEPTH return addresses, the next-free-slot pointer, the occupancy
// count and the ra-track register.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset (ptr, cnt, ra_track only)
//   bus    ras_stack_ctrl_if.slave: push/pop/rollback/ra-track strobes in,
//          RAS_top / RAS_empty / RAS_full / RAS_ra_track out
module ras_stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ras_stack_ctrl_if.slave bus
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [4:0]      ra_track_q, ra_track_d;

  logic            stack_we;
  logic [AW-1:0]   stack_widx;
  logic [XLEN-1:0] stack_wdata;
  logic            rb_any;
  logic            eff_push;
  logic [AW-1:0]   ptr_m1;
  logic [AW+1:0]   cnt_up;

  // Top of stack sits one below the next-free pointer, modulo DEPTH.
  assign ptr_m1 = ptr_q - AW'(1);

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ra_track_d  = ra_track_q;
    stack_we    = 1'b0;
    stack_widx  = ptr_q;
    stack_wdata = bus.push_addr;
    cnt_up      = '0;
    rb_any      = bus.RAS_rollback_pop_id | bus.RAS_rollback_push_id |
                  bus.RAS_rollback_push_ex;
    eff_push    = bus.RAS_push & ~rb_any;

    if (rb_any) begin
      // Rollback applies the net delta; the pointer wraps freely while the
      // count is clamped so repeated undo cannot corrupt occupancy.
      ptr_d  = ptr_q + AW'(bus.RAS_rollback_push_id) +
               AW'(bus.RAS_rollback_push_ex) - AW'(bus.RAS_rollback_pop_id);
      cnt_up = {1'b0, cnt_q} + (AW+2)'(bus.RAS_rollback_push_id) +
               (AW+2)'(bus.RAS_rollback_push_ex);
      if (bus.RAS_rollback_pop_id && cnt_up != '0) begin
        cnt_up = cnt_up - (AW+2)'(1);
      end
      cnt_d = (cnt_up > (AW+2)'(DEPTH)) ? CNT_FULL : cnt_up[AW:0];
    end else if (bus.RAS_push && bus.RAS_pop && cnt_q != '0) begin
      // Pop-then-push of the same frame collapses to replacing the top entry.
      stack_we   = 1'b1;
      stack_widx = ptr_m1;
    end else if (bus.RAS_push) begin
      // When full the write lands on the oldest entry, which is dropped.
      stack_we = 1'b1;
      ptr_d    = ptr_q + AW'(1);
      cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + (AW+1)'(1);
    end else if (bus.RAS_pop && cnt_q != '0) begin
      ptr_d = ptr_m1;
      cnt_d = cnt_q - (AW+1)'(1);
    end

    // A new ra value invalidates any tracked copy, unless software-visible
    // tracking is being written in the same cycle.
    if (bus.WR_ra_track_en) begin
      ra_track_d = bus.WR_ra_track_data;
    end else if (eff_push || bus.RAS_rollback_pop_id) begin
      ra_track_d = 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      ra_track_q <= 5'd1;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ra_track_q <= ra_track_d;
    end
  end

  // Storage is not reset; a push coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (stack_we && rst_n) begin
      stack_q[stack_widx] <= stack_wdata;
    end
  end

  assign bus.RAS_top      = (cnt_q != '0) ? stack_q[ptr_m1] : '0;
  assign bus.RAS_empty    = (cnt_q == '0);
  assign bus.RAS_full     = (cnt_q == CNT_FULL);
  assign bus.RAS_ra_track = ra_track_q;

endmodule

// File: tb/tb_ras_stack_ctrl.sv
// tb_ras_stack_ctrl
// Table-driven bench for ras_stack_ctrl. Each vector drives one cycle of
// strobes and carries the outputs expected after that rising edge; expected
// records go through a scoreboard queue and are compared one cycle later.
module tb_ras_stack_ctrl;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ras_stack_ctrl_if #(.XLEN(XLEN)) bus ();

  ras_stack_ctrl #(.DEPTH(8), .AW(3), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        do_reset;
    logic        push;
    logic        pop;
    logic [31:0] addr;
    logic [2:0]  rb;        // {pop_id, push_id, push_ex}
    logic        wr_en;
    logic [4:0]  wr_data;
    logic [31:0] exp_top;
    logic        exp_empty;
    logic        exp_full;
    logic [4:0]  exp_ra;
  } vec_t;

  typedef struct packed {
    int          tag;
    logic [31:0] top;
    logic        empty;
    logic        full;
    logic [4:0]  ra;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input logic rst, input logic push, input logic pop,
                              input logic [31:0] addr, input logic [2:0] rb,
                              input logic wr_en, input logic [4:0] wd,
                              input logic [31:0] et, input logic ee,
                              input logic ef, input logic [4:0] er);
    vec_t v;
    v.do_reset  = rst;
    v.push      = push;
    v.pop       = pop;
    v.addr      = addr;
    v.rb        = rb;
    v.wr_en     = wr_en;
    v.wr_data   = wd;
    v.exp_top   = et;
    v.exp_empty = ee;
    v.exp_full  = ef;
    v.exp_ra    = er;
    return v;
  endfunction

  task automatic cmp(input string name, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic pushExpected(input int tag, input logic [31:0] top,
                              input logic empty, input logic full,
                              input logic [4:0] ra);
    exp_t e;
    e.tag   = tag;
    e.top   = top;
    e.empty = empty;
    e.full  = full;
    e.ra    = ra;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      cmp("RAS_top",      e.tag, bus.RAS_top,             e.top);
      cmp("RAS_empty",    e.tag, 32'(bus.RAS_empty),      32'(e.empty));
      cmp("RAS_full",     e.tag, 32'(bus.RAS_full),       32'(e.full));
      cmp("RAS_ra_track", e.tag, 32'(bus.RAS_ra_track),   32'(e.ra));
    end
  endtask

  task automatic driveIdle();
    bus.RAS_push             = 1'b0;
    bus.RAS_pop              = 1'b0;
    bus.push_addr            = '0;
    bus.RAS_rollback_pop_id  = 1'b0;
    bus.RAS_rollback_push_id = 1'b0;
    bus.RAS_rollback_push_ex = 1'b0;
    bus.WR_ra_track_en       = 1'b0;
    bus.WR_ra_track_data     = '0;
  endtask

  // Drives one vector at the falling edge, queues its expectation, then
  // checks just after the following rising edge.
  task automatic applyStimulus(input vec_t v, input int tag);
    @(negedge clk);
    rst_n                    = ~v.do_reset;
    bus.RAS_push             = v.push;
    bus.RAS_pop              = v.pop;
    bus.push_addr            = v.addr;
    bus.RAS_rollback_pop_id  = v.rb[2];
    bus.RAS_rollback_push_id = v.rb[1];
    bus.RAS_rollback_push_ex = v.rb[0];
    bus.WR_ra_track_en       = v.wr_en;
    bus.WR_ra_track_data     = v.wr_data;
    pushExpected(tag, v.exp_top, v.exp_empty, v.exp_full, v.exp_ra);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    driveIdle();
    repeat (2) @(posedge clk);
    #1;
    pushExpected(-1, 32'h0, 1'b1, 1'b0, 5'd1);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push / pop ordering.
    vecs.push_back(mk(0,1,0,32'h100,3'b000,0,0, 32'h100,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h104,3'b000,0,0, 32'h104,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h108,3'b000,0,0, 32'h108,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h104,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h100,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));

    // Overflow: nine pushes, oldest entry overwritten, then drain.
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(0,1,0,32'h200 + 32'(4*k),3'b000,0,0,
                        32'h200 + 32'(4*k),0,(k >= 7),5'd1));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0,0,1,32'h0,3'b000,0,0,
                        (j < 8) ? 32'h220 - 32'(4*j) : 32'h0,(j == 8),0,5'd1));

    // Double pop undone by both push rollbacks; push during reset is lost.
    vecs.push_back(mk(1,1,0,32'hDEAD,3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h300, 3'b000,0,0, 32'h300,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h304, 3'b000,0,0, 32'h304,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,   3'b000,0,0, 32'h300,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,   3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,   3'b011,0,0, 32'h304,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,   3'b000,0,0, 32'h300,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,   3'b000,0,0, 32'h0,  1,0,5'd1));

    // Push undone by rollback_pop_id; the same-cycle push is ignored.
    vecs.push_back(mk(1,0,0,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h400,3'b000,0,0, 32'h400,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h404,3'b000,0,0, 32'h404,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h4FF,3'b100,0,0, 32'h400,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));

    // Push+pop replaces the top; underflow pop leaves the pointer alone.
    vecs.push_back(mk(1,0,0,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h500,3'b000,0,0, 32'h500,0,0,5'd1));
    vecs.push_back(mk(0,1,1,32'h600,3'b000,0,0, 32'h600,0,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h700,3'b000,0,0, 32'h700,0,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,  3'b010,0,0, 32'h404,0,0,5'd1));

    // ra-track write priority and invalidation.
    vecs.push_back(mk(0,0,0,32'h0,  3'b000,1,5'd5, 32'h404,0,0,5'd5));
    vecs.push_back(mk(0,1,0,32'h800,3'b000,0,0,    32'h800,0,0,5'd1));
    vecs.push_back(mk(0,1,0,32'h804,3'b000,1,5'd0, 32'h804,0,0,5'd0));
    vecs.push_back(mk(0,0,0,32'h0,  3'b100,0,0,    32'h800,0,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,  3'b100,1,5'd7, 32'h404,0,0,5'd7));
    vecs.push_back(mk(0,0,0,32'h0,  3'b000,1,5'd9, 32'h404,0,0,5'd9));
    vecs.push_back(mk(0,0,0,32'h0,  3'b001,0,0,    32'h800,0,0,5'd9));

    // Count clamps at DEPTH while the pointer still wraps.
    vecs.push_back(mk(1,0,0,32'h0,3'b000,0,0, 32'h0,1,0,5'd1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0,1,0,32'hA00 + 32'(4*k),3'b000,0,0,
                        32'hA00 + 32'(4*k),0,(k == 7),5'd1));
    vecs.push_back(mk(0,0,0,32'h0,3'b011,0,0, 32'hA04,0,1,5'd1));
    vecs.push_back(mk(0,0,1,32'h0,3'b000,0,0, 32'hA00,0,0,5'd1));

    // Count clamps at 0 while the pointer wraps down to DEPTH-1.
    vecs.push_back(mk(1,0,0,32'h0,  3'b000,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,  3'b100,0,0, 32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'hB00,3'b000,0,0, 32'hB00,0,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,  3'b010,0,0, 32'hA00,0,0,5'd1));

    // Lead-in for the asynchronous reset sequence.
    vecs.push_back(mk(1,0,0,32'h0,  3'b000,0,0,    32'h0,  1,0,5'd1));
    vecs.push_back(mk(0,1,0,32'hC00,3'b000,0,0,    32'hC00,0,0,5'd1));
    vecs.push_back(mk(0,0,0,32'h0,  3'b000,1,5'd12,32'hC00,0,0,5'd12));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset dropped between edges must clear outputs before the next edge,
    // and a push presented on that edge must be lost.
    #2;
    bus.RAS_push  = 1'b1;
    bus.push_addr = 32'hC04;
    rst_n         = 1'b0;
    #1;
    pushExpected(1000, 32'h0, 1'b1, 1'b0, 5'd1);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpected(1001, 32'h0, 1'b1, 1'b0, 5'd1);
    checkOutput();
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pushExpected(1002, 32'h0, 1'b1, 1'b0, 5'd1);
    checkOutput();

    cmp("scoreboard_drained", 2000, 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
